// File: rtl/if_hart_fetch_if.sv
// Fetch-stage bundle: hart commands from ID/EX, EX redirect, instruction memory
// port and the IF/ID register outputs.
interface if_hart_fetch_if #(
    parameter int unsigned HART_ID_W = 2,
    parameter int unsigned WORD_W    = 32
);
    localparam int unsigned NUM_HARTS = 1 << HART_ID_W;

    logic                 stall;
    logic                 flush;
    logic                 br_taken;
    logic [HART_ID_W-1:0] br_hart_id;
    logic [WORD_W-1:0]    br_addr;
    logic                 id_hstart;
    logic [HART_ID_W-1:0] id_hs_id;
    logic [WORD_W-1:0]    id_hs_pc;
    logic                 id_hkill;
    logic                 id_hidle;
    logic [HART_ID_W-1:0] id_set_hid;
    logic [WORD_W-1:0]    imem_rd_data;
    logic [WORD_W-1:0]    imem_addr;
    logic                 imem_rd_en;
    logic [WORD_W-1:0]    if_pc;
    logic [WORD_W-1:0]    if_insn;
    logic                 if_en;
    logic [HART_ID_W-1:0] if_hart_id;
    logic [NUM_HARTS-1:0] hart_active;

    modport master (
        input  stall, flush, br_taken, br_hart_id, br_addr,
        input  id_hstart, id_hs_id, id_hs_pc, id_hkill, id_hidle, id_set_hid,
        input  imem_rd_data,
        output imem_addr, imem_rd_en,
        output if_pc, if_insn, if_en, if_hart_id, hart_active
    );

    modport slave (
        output stall, flush, br_taken, br_hart_id, br_addr,
        output id_hstart, id_hs_id, id_hs_pc, id_hkill, id_hidle, id_set_hid,
        output imem_rd_data,
        input  imem_addr, imem_rd_en,
        input  if_pc, if_insn, if_en, if_hart_id, hart_active
    );
endinterface

// File: rtl/if_hart_fetch.sv
// Multi-hart fetch stage: round-robin hart select, per-hart PC/state with
// start/kill/idle/redirect commands, and the IF/ID pipeline register.
module if_hart_fetch #(
    parameter int unsigned      HART_ID_W = 2,
    parameter int unsigned      WORD_W    = 32,
    parameter logic [WORD_W-1:0] RESET_PC = '0,
    parameter logic [WORD_W-1:0] NOP_INSN = 32'h0000_0013
) (
    input logic               clk_i,
    input logic               reset_i,
    if_hart_fetch_if.master   bus
);
    localparam int unsigned NUM_HARTS = 1 << HART_ID_W;

    logic [WORD_W-1:0]    pc_q [NUM_HARTS];
    logic [WORD_W-1:0]    pc_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] active_q, active_d;
    logic [HART_ID_W-1:0] last_q, last_d;
    logic [WORD_W-1:0]    if_pc_q, if_pc_d;
    logic [WORD_W-1:0]    if_insn_q, if_insn_d;
    logic                 if_en_q, if_en_d;
    logic [HART_ID_W-1:0] if_hid_q, if_hid_d;

    logic [HART_ID_W-1:0] sel;
    logic [HART_ID_W-1:0] idx;
    logic                 found;
    logic                 any;
    logic [NUM_HARTS-1:0] hit;

    // Round-robin: scan last+1 .. last, the final step wrapping back onto last.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        any   = |active_q;
        for (int i = 1; i <= int'(NUM_HARTS); i++) begin
            idx = last_q + HART_ID_W'(i);
            if (!found && active_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign bus.imem_rd_en  = any & ~bus.stall;
    assign bus.imem_addr   = any ? pc_q[sel] : '0;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_insn     = if_insn_q;
    assign bus.if_en       = if_en_q;
    assign bus.if_hart_id  = if_hid_q;
    assign bus.hart_active = active_q;

    always_comb begin
        pc_d      = pc_q;
        active_d  = active_q;
        last_d    = last_q;
        if_pc_d   = if_pc_q;
        if_insn_d = if_insn_q;
        if_en_d   = if_en_q;
        if_hid_d  = if_hid_q;
        hit       = '0;
        if (!bus.stall) begin
            for (int h = 0; h < int'(NUM_HARTS); h++) begin
                if (bus.id_hkill && bus.id_set_hid == HART_ID_W'(h)) begin
                    active_d[h] = 1'b0;
                    pc_d[h]     = RESET_PC;
                    hit[h]      = 1'b1;
                end else if (bus.id_hidle && bus.id_set_hid == HART_ID_W'(h)) begin
                    active_d[h] = 1'b0;
                    hit[h]      = 1'b1;
                end else if (bus.id_hstart && bus.id_hs_id == HART_ID_W'(h)) begin
                    active_d[h] = 1'b1;
                    pc_d[h]     = bus.id_hs_pc;
                    hit[h]      = 1'b1;
                end else if (bus.br_taken && bus.br_hart_id == HART_ID_W'(h)) begin
                    pc_d[h]     = bus.br_addr;
                    hit[h]      = 1'b1;
                end else if (sel == HART_ID_W'(h) && any && !bus.flush) begin
                    pc_d[h]     = pc_q[h] + WORD_W'(4);
                end
            end
            // A command landing on the selected hart overrides its fetch.
            if (bus.flush || !any || hit[sel]) begin
                if_pc_d   = '0;
                if_insn_d = NOP_INSN;
                if_en_d   = 1'b0;
                if_hid_d  = '0;
            end else begin
                if_pc_d   = pc_q[sel];
                if_insn_d = bus.imem_rd_data;
                if_en_d   = 1'b1;
                if_hid_d  = sel;
                last_d    = sel;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int h = 0; h < int'(NUM_HARTS); h++) begin
                pc_q[h] <= (h == 0) ? RESET_PC : '0;
            end
            active_q  <= NUM_HARTS'(1);
            last_q    <= '1;
            if_pc_q   <= '0;
            if_insn_q <= NOP_INSN;
            if_en_q   <= 1'b0;
            if_hid_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            active_q  <= active_d;
            last_q    <= last_d;
            if_pc_q   <= if_pc_d;
            if_insn_q <= if_insn_d;
            if_en_q   <= if_en_d;
            if_hid_q  <= if_hid_d;
        end
    end
endmodule

// File: tb/tb_if_hart_fetch.sv
// Directed bench for if_hart_fetch: reset, round-robin, stall, flush/redirect,
// kill/start and asynchronous reset, against hand-computed values.
module tb_if_hart_fetch;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    if_hart_fetch_if #(.HART_ID_W(2), .WORD_W(32)) bus ();

    if_hart_fetch #(
        .HART_ID_W(2),
        .WORD_W   (32),
        .RESET_PC (32'h0),
        .NOP_INSN (32'h0000_0013)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    assign bus.imem_rd_data = bus.imem_addr | 32'hA000_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic en, input logic [31:0] pc,
                            input logic [1:0] hid);
        chk({tag, ".en"}, 64'(bus.if_en), 64'(en));
        chk({tag, ".pc"}, 64'(bus.if_pc), 64'(pc));
        chk({tag, ".hid"}, 64'(bus.if_hart_id), 64'(hid));
        chk({tag, ".insn"}, 64'(bus.if_insn), en ? 64'(pc | 32'hA000_0000) : 64'h13);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_hart_id = '0;
        bus.br_addr    = '0;
        bus.id_hstart  = 1'b0;
        bus.id_hs_id   = '0;
        bus.id_hs_pc   = '0;
        bus.id_hkill   = 1'b0;
        bus.id_hidle   = 1'b0;
        bus.id_set_hid = '0;
        #12;
        chk_ifid("reset", 1'b0, 32'h0, 2'd0);
        chk("reset.active", 64'(bus.hart_active), 64'h1);
        chk("reset.imem_addr", 64'(bus.imem_addr), 64'h0);
        chk("reset.rd_en", 64'(bus.imem_rd_en), 64'h1);
        reset = 1'b0;

        // Single hart streaming
        step(); chk_ifid("t1.c0", 1'b1, 32'h0, 2'd0);
        step(); chk_ifid("t1.c1", 1'b1, 32'h4, 2'd0);
        step(); chk_ifid("t1.c2", 1'b1, 32'h8, 2'd0);

        // Start hart 2 at 0x100
        bus.id_hstart = 1'b1; bus.id_hs_id = 2'd2; bus.id_hs_pc = 32'h100;
        step(); chk_ifid("t2.c0", 1'b1, 32'hC, 2'd0);
        chk("t2.active", 64'(bus.hart_active), 64'h5);
        bus.id_hstart = 1'b0;
        step(); chk_ifid("t2.c1", 1'b1, 32'h100, 2'd2);
        step(); chk_ifid("t2.c2", 1'b1, 32'h10, 2'd0);
        step(); chk_ifid("t2.c3", 1'b1, 32'h104, 2'd2);

        // Stall three cycles
        bus.stall = 1'b1;
        #1;
        chk("t3.rd_en", 64'(bus.imem_rd_en), 64'h0);
        chk("t3.addr", 64'(bus.imem_addr), 64'h14);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_ifid("t3.hold", 1'b1, 32'h104, 2'd2);
            chk("t3.addr_hold", 64'(bus.imem_addr), 64'h14);
        end
        bus.stall = 1'b0;
        step(); chk_ifid("t3.r0", 1'b1, 32'h14, 2'd0);
        step(); chk_ifid("t3.r1", 1'b1, 32'h108, 2'd2);

        // Redirect hart 0 together with flush
        bus.br_taken = 1'b1; bus.br_hart_id = 2'd0; bus.br_addr = 32'h40; bus.flush = 1'b1;
        step(); chk_ifid("t4.bubble", 1'b0, 32'h0, 2'd0);
        bus.br_taken = 1'b0; bus.flush = 1'b0;
        step(); chk_ifid("t4.c0", 1'b1, 32'h40, 2'd0);
        step(); chk_ifid("t4.c1", 1'b1, 32'h10C, 2'd2);

        // Kill hart 0, then hart 2
        bus.id_hkill = 1'b1; bus.id_set_hid = 2'd0;
        step(); chk_ifid("t5.k0", 1'b0, 32'h0, 2'd0);
        chk("t5.active0", 64'(bus.hart_active), 64'h4);
        bus.id_set_hid = 2'd2;
        step(); chk_ifid("t5.k2", 1'b0, 32'h0, 2'd0);
        chk("t5.active2", 64'(bus.hart_active), 64'h0);
        chk("t5.rd_en", 64'(bus.imem_rd_en), 64'h0);
        chk("t5.addr", 64'(bus.imem_addr), 64'h0);
        bus.id_hkill = 1'b0;
        step(); chk_ifid("t5.idle", 1'b0, 32'h0, 2'd0);
        bus.id_hstart = 1'b1; bus.id_hs_id = 2'd0; bus.id_hs_pc = 32'h200;
        step(); chk_ifid("t5.start", 1'b0, 32'h0, 2'd0);
        chk("t5.active_s", 64'(bus.hart_active), 64'h1);
        bus.id_hstart = 1'b0;
        step(); chk_ifid("t5.resume", 1'b1, 32'h200, 2'd0);

        // Two harts running, then asynchronous reset mid-cycle
        bus.id_hstart = 1'b1; bus.id_hs_id = 2'd1; bus.id_hs_pc = 32'h300;
        step(); chk_ifid("t6.c0", 1'b1, 32'h204, 2'd0);
        bus.id_hstart = 1'b0;
        step(); chk_ifid("t6.c1", 1'b1, 32'h300, 2'd1);
        chk("t6.active", 64'(bus.hart_active), 64'h3);
        #2 reset = 1'b1;
        #1;
        chk_ifid("t6.rst", 1'b0, 32'h0, 2'd0);
        chk("t6.rst_active", 64'(bus.hart_active), 64'h1);
        chk("t6.rst_addr", 64'(bus.imem_addr), 64'h0);
        #1 reset = 1'b0;
        step(); chk_ifid("t6.first", 1'b1, 32'h0, 2'd0);

        // Kill and start on the same hart: kill wins
        bus.id_hkill = 1'b1; bus.id_set_hid = 2'd0;
        bus.id_hstart = 1'b1; bus.id_hs_id = 2'd0; bus.id_hs_pc = 32'h500;
        step(); chk_ifid("t7.kill", 1'b0, 32'h0, 2'd0);
        chk("t7.active", 64'(bus.hart_active), 64'h0);
        bus.id_hkill = 1'b0; bus.id_hstart = 1'b0;
        step(); chk_ifid("t7.idle", 1'b0, 32'h0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
